// File: rtl/mod_barrett_u_precompute_32b_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett_u_precompute_32b_pkg
// Purpose  : Shared widths, iteration count and FSM encoding for the Barrett
//            U = floor(2^64 / M) precompute engine.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mod_barrett_u_precompute_32b_pkg;

  localparam int MOD_W  = 32;  // modulus width
  localparam int U_W    = 64;  // Barrett constant width
  localparam int REM_W  = 33;  // remainder width (one guard bit over M)
  localparam int ITER_N = 65;  // dividend 2^64 has 65 bits
  localparam int CNT_W  = 7;   // holds ITER_N

  localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(ITER_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mod_barrett_u_precompute_32b_pkg
`default_nettype wire

// File: rtl/mod_barrett_u_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett_u_div_step
// Purpose  : One radix-2 restoring-division step. Shifts the next dividend
//            bit into the remainder and conditionally subtracts the modulus.
// Ports    : i_rem   [32:0] current remainder R (R < M)
//            i_dbit         next dividend bit, MSB first
//            i_mod   [31:0] modulus M
//            o_rem   [32:0] updated remainder
//            o_qbit         quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module mod_barrett_u_div_step
  import mod_barrett_u_precompute_32b_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_dbit,
  input  logic [MOD_W-1:0] i_mod,
  output logic [REM_W-1:0] o_rem,
  output logic             o_qbit
);

  logic [REM_W-1:0] w_shift;
  logic [REM_W-1:0] w_mod_ext;
  logic [REM_W-1:0] w_diff;

  always_comb begin
    // R < M keeps the top remainder bit zero, so a plain shift cannot overflow.
    w_shift   = (i_rem << 1) | {{(REM_W-1){1'b0}}, i_dbit};
    w_mod_ext = {1'b0, i_mod};
    w_diff    = w_shift - w_mod_ext;
    o_qbit    = (w_shift >= w_mod_ext);
    o_rem     = o_qbit ? w_diff : w_shift;
  end

endmodule : mod_barrett_u_div_step
`default_nettype wire

// File: rtl/mod_barrett_u_precompute_32b.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett_u_precompute_32b
// Purpose  : Sequential precompute of the Barrett constant
//            U = floor(2^64 / M) mod 2^64, one quotient bit per enabled cycle.
// Ports    : iClk, iRstN (async, active-low), iEn (clock enable),
//            iClr (sync clear, beats iEn), iStart, iMod[31:0] (modulus),
//            oBusy, oDone (1-cycle pulse), oErr, oU[63:0] (result).
// Config   : BARRETT_U_MODCHECK_EN - when defined, a modulus with bit 31
//            clear is rejected (oErr=1, oU=0) one cycle after acceptance.
//            When undefined, every modulus is divided and oErr is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mod_barrett_u_precompute_32b
  import mod_barrett_u_precompute_32b_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iStart,
  input  logic [MOD_W-1:0] iMod,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr,
  output logic [U_W-1:0]   oU
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [REM_W-1:0]   rem_q,   rem_d;
  logic [U_W:0]       quo_q,   quo_d;
  logic [MOD_W-1:0]   mod_q,   mod_d;
  logic [U_W-1:0]     u_q,     u_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               step_dbit;
  logic [REM_W-1:0]   step_rem;
  logic               step_qbit;
  logic [U_W:0]       quo_shift;
  logic               mod_bad;

  // 2^64 as a dividend is a single 1 followed by 64 zeros.
  assign step_dbit = (cnt_q == ITER_LOAD);

  mod_barrett_u_div_step u_step (
    .i_rem  (rem_q),
    .i_dbit (step_dbit),
    .i_mod  (mod_q),
    .o_rem  (step_rem),
    .o_qbit (step_qbit)
  );

  // Bit 64 of the quotient is shifted out of the top and never reaches oU.
  assign quo_shift = (quo_q << 1) | {{U_W{1'b0}}, step_qbit};

`ifdef BARRETT_U_MODCHECK_EN
  logic err_q, err_d;
  assign mod_bad = ~mod_q[MOD_W-1];
  assign oErr    = err_q;
`else
  assign mod_bad = 1'b0;
  assign oErr    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    mod_d   = mod_q;
    u_d     = u_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef BARRETT_U_MODCHECK_EN
    err_d   = err_q;
`endif

    if (iClr) begin
      state_d = IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = '0;
      mod_d   = '0;
      u_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef BARRETT_U_MODCHECK_EN
      err_d   = 1'b0;
`endif
    end else if (iEn) begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            mod_d   = iMod;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = ITER_LOAD;
            busy_d  = 1'b1;
            state_d = RUN;
`ifdef BARRETT_U_MODCHECK_EN
            err_d   = 1'b0;
`endif
          end
        end

        RUN: begin
          if (mod_bad) begin
            // Rejected modulus: finish on the first iteration with a zero result.
            u_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
`ifdef BARRETT_U_MODCHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            rem_d = step_rem;
            quo_d = quo_shift;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              u_d     = quo_shift[U_W-1:0];
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end

        DONE: begin
          done_d  = 1'b0;
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      mod_q   <= '0;
      u_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      mod_q   <= mod_d;
      u_q     <= u_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BARRETT_U_MODCHECK_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oU    = u_q;

endmodule : mod_barrett_u_precompute_32b
`default_nettype wire
